// File: rtl/calc_pkg.sv
// Shared encodings and helpers for the N-digit keypad calculator.
package calc_pkg;

   localparam int MAX_DIGITS = 4;

   typedef enum logic [1:0] {
      MODE_ADD = 2'd0,
      MODE_SUB = 2'd1,
      MODE_MUL = 2'd2,
      MODE_DIV = 2'd3
   } mode_t;

   typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;

   // Unused upper digits are zero, so the widest form serves every DIGITS.
   function automatic logic [31:0] bcd2bin(input logic [4*MAX_DIGITS-1:0] digits);
      logic [31:0] v;
      v = '0;
      for (int i = MAX_DIGITS - 1; i >= 0; i--)
         v = v * 32'd10 + {28'd0, digits[4*i +: 4]};
      return v;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: start loads a binary value, done pulses once
// the BCD vector is valid, RW cycles after start.
module bin2bcd_seq #(
   parameter int RW         = 14,
   parameter int RES_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [RW-1:0]           value,
   output logic [4*RES_DIGITS-1:0] bcd,
   output logic                    done
);

   localparam int CW = $clog2(RW);

   logic [RW-1:0]           sr_q;
   logic [CW-1:0]           cnt_q;
   logic                    running_q;
   logic [4*RES_DIGITS-1:0] adj;

   always_comb begin
      adj = bcd;
      for (int i = 0; i < RES_DIGITS; i++)
         if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
   end

   // The load cycle performs the first shift: the BCD field starts at zero,
   // so no add-3 correction applies to it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q      <= '0;
         cnt_q     <= '0;
         running_q <= 1'b0;
         bcd       <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            bcd       <= {{(4*RES_DIGITS-1){1'b0}}, value[RW-1]};
            sr_q      <= value << 1;
            cnt_q     <= CW'(RW - 1);
            running_q <= 1'b1;
         end else if (running_q) begin
            bcd   <= (adj << 1) | {{(4*RES_DIGITS-1){1'b0}}, sr_q[RW-1]};
            sr_q  <= sr_q << 1;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               running_q <= 1'b0;
               done      <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/calc_ndigit_seq.sv
// N-digit BCD keypad calculator: digit entry, multi-cycle add/sub/mul/div,
// and sequential binary-to-BCD conversion of the result.
module calc_ndigit_seq
   import calc_pkg::*;
#(
   parameter int DIGITS     = 2,
   parameter int W          = $clog2(10**DIGITS),
   parameter int RES_DIGITS = 2*DIGITS,
   parameter int RW         = 2*W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [3:0]              key_in,
   input  logic                    num_valid,
   input  logic                    sel_operand,
   input  logic                    clear,
   input  logic [1:0]              mode_arith,
   input  logic                    start,
   output logic [4*DIGITS-1:0]     first_bcd,
   output logic [4*DIGITS-1:0]     second_bcd,
   output logic [4*RES_DIGITS-1:0] result_bcd,
   output logic                    negative,
   output logic                    div_err,
   output logic                    busy,
   output logic                    done
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

   state_t state_q, state_n;
   mode_t  mode_q;

   logic [W-1:0]  a_q, b_q;
   logic [RW-1:0] acc_q, mcand_q, acc_n;
   logic [W-1:0]  mplier_q, rem_q, quo_q, rem_n, quo_n;
   logic [W:0]    r_sh;
   logic [CW-1:0] cnt_q;
   logic          neg_pend_q, err_pend_q;

   logic                    calc_last, conv_start, conv_done;
   logic [RW-1:0]           calc_value;
   logic [4*RES_DIGITS-1:0] conv_bcd;
   logic [4*DIGITS+3:0]     first_sh, second_sh;

   assign first_sh  = {first_bcd, key_in};
   assign second_sh = {second_bcd, key_in};
   assign busy      = (state_q != IDLE);

   // One shift-add / restoring-division step; calc_value is what the
   // converter receives on the final CALC cycle.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      acc_n      = acc_q + (mplier_q[0] ? mcand_q : '0);
      r_sh       = {rem_q, quo_q[W-1]};
      rem_n      = r_sh[W-1:0];
      quo_n      = {quo_q[W-2:0], 1'b0};
      calc_last  = 1'b1;
      calc_value = '0;
      if (r_sh >= {1'b0, b_q}) begin
         rem_n = W'(r_sh - {1'b0, b_q});
         quo_n = {quo_q[W-2:0], 1'b1};
      end
      case (mode_q)
         MODE_ADD: calc_value = {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
         MODE_SUB: calc_value = (b_q > a_q) ? {{W{1'b0}}, b_q - a_q}
                                            : {{W{1'b0}}, a_q - b_q};
         MODE_MUL: begin
            calc_last  = (cnt_q == LAST_STEP);
            calc_value = acc_n;
         end
         MODE_DIV: begin
            calc_last  = (b_q == '0) || (cnt_q == LAST_STEP);
            calc_value = (b_q == '0) ? '0 : {{W{1'b0}}, quo_n};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_n;
   end

   always_comb begin
      state_n    = state_q;
      conv_start = 1'b0;
      case (state_q)
         IDLE: if (start && !clear) state_n = CALC;
         CALC: if (calc_last) begin
            conv_start = 1'b1;
            state_n    = CONV;
         end
         CONV: if (conv_done) state_n = DONE;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_bcd  <= '0;
         second_bcd <= '0;
         result_bcd <= '0;
         negative   <= 1'b0;
         div_err    <= 1'b0;
         done       <= 1'b0;
         mode_q     <= MODE_ADD;
         a_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         cnt_q      <= '0;
         neg_pend_q <= 1'b0;
         err_pend_q <= 1'b0;
      end else begin
         // NOTE: non-blocking everywhere here, so each register sees pre-edge values.
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (clear) begin
                  first_bcd  <= '0;
                  second_bcd <= '0;
                  result_bcd <= '0;
                  negative   <= 1'b0;
                  div_err    <= 1'b0;
               end else if (start) begin
                  mode_q   <= mode_t'(mode_arith);
                  a_q      <= W'(bcd2bin((4*MAX_DIGITS)'(first_bcd)));
                  b_q      <= W'(bcd2bin((4*MAX_DIGITS)'(second_bcd)));
                  acc_q    <= '0;
                  mcand_q  <= RW'(bcd2bin((4*MAX_DIGITS)'(first_bcd)));
                  mplier_q <= W'(bcd2bin((4*MAX_DIGITS)'(second_bcd)));
                  rem_q    <= '0;
                  quo_q    <= W'(bcd2bin((4*MAX_DIGITS)'(first_bcd)));
                  cnt_q    <= '0;
               end else if (num_valid && key_in <= 4'd9) begin
                  if (sel_operand) second_bcd <= second_sh[4*DIGITS-1:0];
                  else             first_bcd  <= first_sh[4*DIGITS-1:0];
               end
            end
            CALC: begin
               acc_q    <= acc_n;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               rem_q    <= rem_n;
               quo_q    <= quo_n;
               cnt_q    <= cnt_q + 1'b1;
               if (calc_last) begin
                  neg_pend_q <= (mode_q == MODE_SUB) && (b_q > a_q);
                  err_pend_q <= (mode_q == MODE_DIV) && (b_q == '0);
               end
            end
            CONV: if (conv_done) begin
               result_bcd <= conv_bcd;
               negative   <= neg_pend_q;
               div_err    <= err_pend_q;
               done       <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   bin2bcd_seq #(.RW(RW), .RES_DIGITS(RES_DIGITS)) u_bin2bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (conv_start),
      .value (calc_value),
      .bcd   (conv_bcd),
      .done  (conv_done)
   );

endmodule

// File: tb/tb_calc_ndigit_seq.sv
// Self-checking bench for calc_ndigit_seq (DIGITS=2): vector table through
// a result scoreboard, plus entry, busy-interference and reset sequences.
module tb_calc_ndigit_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  key_in;
   logic        num_valid, sel_operand, clear, start;
   logic [1:0]  mode_arith;
   logic [7:0]  first_bcd, second_bcd;
   logic [15:0] result_bcd;
   logic        negative, div_err, busy, done;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [15:0] res;
      logic        neg;
      logic        err;
      int          lat;
   } exp_t;

   typedef struct {
      logic [7:0] f;
      logic [7:0] s;
      logic [1:0] m;
      exp_t       e;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[14];

   calc_ndigit_seq #(.DIGITS(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in),
      .num_valid   (num_valid),
      .sel_operand (sel_operand),
      .clear       (clear),
      .mode_arith  (mode_arith),
      .start       (start),
      .first_bcd   (first_bcd),
      .second_bcd  (second_bcd),
      .result_bcd  (result_bcd),
      .negative    (negative),
      .div_err     (div_err),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic press(input logic sel, input logic [3:0] k);
      @(negedge clk);
      sel_operand = sel;
      key_in      = k;
      num_valid   = 1'b1;
      @(negedge clk);
      num_valid   = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic load_ops(input logic [7:0] f, input logic [7:0] s);
      pulse_clear();
      press(1'b0, f[7:4]);
      press(1'b0, f[3:0]);
      press(1'b1, s[7:4]);
      press(1'b1, s[3:0]);
   endtask

   // flags[0]: keys/start/clear pulsed while busy; flags[1]: key with start.
   task automatic run_op(input logic [7:0] f, input logic [7:0] s, input logic [1:0] m,
                         input exp_t e, input logic [1:0] flags);
      exp_t got_e;
      bit   got;
      int   lat, busy_cnt, extra;
      load_ops(f, s);
      sb_q.push_back(e);
      @(negedge clk);
      mode_arith = m;
      start      = 1'b1;
      if (flags[1]) begin
         sel_operand = 1'b0;
         key_in      = 4'd3;
         num_valid   = 1'b1;
      end
      @(negedge clk);
      start     = 1'b0;
      num_valid = 1'b0;
      got = 0; lat = 0; busy_cnt = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         if (i > 0) @(negedge clk);
         if (done) begin
            got = 1;
            lat = i + 1;
            check("busy_at_done", {31'd0, busy}, 32'd1);
         end else if (busy) busy_cnt++;
         if (flags[0] && i == 3) begin
            sel_operand = 1'b0; key_in = 4'd5;
            num_valid = 1'b1; start = 1'b1; clear = 1'b1;
         end
         if (flags[0] && i == 4) begin
            num_valid = 1'b0; start = 1'b0; clear = 1'b0;
         end
      end
      got_e = sb_q.pop_front();
      if (!got) begin
         check("done_timeout", 32'd0, 32'd1);
         return;
      end
      check("result_bcd", {16'd0, result_bcd}, {16'd0, got_e.res});
      check("negative",   {31'd0, negative},   {31'd0, got_e.neg});
      check("div_err",    {31'd0, div_err},    {31'd0, got_e.err});
      check("latency",    lat,                 got_e.lat);
      check("busy_cycles", busy_cnt,           got_e.lat - 1);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("idle_after",     {31'd0, busy}, 32'd0);
      if (flags != 2'b00) begin
         check("first_kept",  {24'd0, first_bcd},  {24'd0, f});
         check("second_kept", {24'd0, second_bcd}, {24'd0, s});
      end
      if (flags[0]) begin
         extra = 0;
         for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) extra++;
         end
         check("no_second_done", extra, 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{8'h99, 8'h99, 2'd0, '{16'h0198, 1'b0, 1'b0, 16}};
      vecs[1]  = '{8'h12, 8'h47, 2'd1, '{16'h0035, 1'b1, 1'b0, 16}};
      vecs[2]  = '{8'h99, 8'h99, 2'd2, '{16'h9801, 1'b0, 1'b0, 22}};
      vecs[3]  = '{8'h47, 8'h12, 2'd1, '{16'h0035, 1'b0, 1'b0, 16}};
      vecs[4]  = '{8'h95, 8'h07, 2'd3, '{16'h0013, 1'b0, 1'b0, 22}};
      vecs[5]  = '{8'h95, 8'h00, 2'd3, '{16'h0000, 1'b0, 1'b1, 16}};
      vecs[6]  = '{8'h00, 8'h00, 2'd0, '{16'h0000, 1'b0, 1'b0, 16}};
      vecs[7]  = '{8'h50, 8'h50, 2'd1, '{16'h0000, 1'b0, 1'b0, 16}};
      vecs[8]  = '{8'h00, 8'h37, 2'd2, '{16'h0000, 1'b0, 1'b0, 22}};
      vecs[9]  = '{8'h07, 8'h95, 2'd3, '{16'h0000, 1'b0, 1'b0, 22}};
      vecs[10] = '{8'h99, 8'h01, 2'd3, '{16'h0099, 1'b0, 1'b0, 22}};
      vecs[11] = '{8'h63, 8'h45, 2'd2, '{16'h2835, 1'b0, 1'b0, 22}};
      vecs[12] = '{8'h81, 8'h09, 2'd3, '{16'h0009, 1'b0, 1'b0, 22}};
      vecs[13] = '{8'h58, 8'h67, 2'd0, '{16'h0125, 1'b0, 1'b0, 16}};

      rst_n = 1'b0; key_in = '0; num_valid = 1'b0; sel_operand = 1'b0;
      clear = 1'b0; mode_arith = '0; start = 1'b0;
      #23;
      check("rst_first",  {24'd0, first_bcd},  32'd0);
      check("rst_second", {24'd0, second_bcd}, 32'd0);
      check("rst_result", {16'd0, result_bcd}, 32'd0);
      check("rst_flags",  {28'd0, negative, div_err, busy, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Digit entry, invalid key, clear priority over a key.
      pulse_clear();
      press(1'b0, 4'd4); press(1'b0, 4'd2); press(1'b0, 4'd7);
      check("entry_27", {24'd0, first_bcd}, 32'h27);
      press(1'b0, 4'd12);
      check("key12_ignored", {24'd0, first_bcd}, 32'h27);
      press(1'b1, 4'd5);
      check("second_05", {24'd0, second_bcd}, 32'h05);
      check("first_untouched", {24'd0, first_bcd}, 32'h27);
      @(negedge clk);
      clear = 1'b1; num_valid = 1'b1; sel_operand = 1'b0; key_in = 4'd6;
      @(negedge clk);
      clear = 1'b0; num_valid = 1'b0;
      check("clear_first", {24'd0, first_bcd}, 32'h00);
      check("clear_second", {24'd0, second_bcd}, 32'h00);

      foreach (vecs[i]) run_op(vecs[i].f, vecs[i].s, vecs[i].m, vecs[i].e, 2'b00);

      // Operand edits must not touch the held result.
      press(1'b0, 4'd8);
      check("result_held", {16'd0, result_bcd}, 32'h0125);

      run_op(8'h99, 8'h99, 2'd2, '{16'h9801, 1'b0, 1'b0, 22}, 2'b01);
      run_op(8'h21, 8'h04, 2'd0, '{16'h0025, 1'b0, 1'b0, 16}, 2'b10);

      run_op(8'h95, 8'h00, 2'd3, '{16'h0000, 1'b0, 1'b1, 16}, 2'b00);
      run_op(8'h12, 8'h47, 2'd1, '{16'h0035, 1'b1, 1'b0, 16}, 2'b00);
      pulse_clear();
      check("clear_result", {16'd0, result_bcd}, 32'd0);
      check("clear_negative", {31'd0, negative}, 32'd0);
      run_op(8'h95, 8'h00, 2'd3, '{16'h0000, 1'b0, 1'b1, 16}, 2'b00);
      run_op(8'h99, 8'h99, 2'd0, '{16'h0198, 1'b0, 1'b0, 16}, 2'b00);
      check("err_cleared_by_add", {31'd0, div_err}, 32'd0);

      // Asynchronous reset in the middle of a multiply's conversion.
      load_ops(8'h99, 8'h99);
      @(negedge clk);
      mode_arith = 2'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      check("busy_before_reset", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_result", {16'd0, result_bcd}, 32'd0);
      check("mid_rst_ops", {16'd0, first_bcd, second_bcd}, 32'd0);
      check("mid_rst_flags", {28'd0, negative, div_err, busy, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'h03, 8'h04, 2'd2, '{16'h0012, 1'b0, 1'b0, 22}, 2'b00);

      check("scoreboard_empty", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
